// File: rtl/tap_pkg.sv
// Shared definitions for the 1149.1 TAP controller and its instruction register.
// State codes follow the standard hex encoding so TAPState can be read directly.
package tap_pkg;

    localparam int IR_WIDTH = 3;

    typedef enum logic [3:0] {
        Ex2DR   = 4'h0,
        Ex1DR   = 4'h1,
        ShDR    = 4'h2,
        PauseDR = 4'h3,
        SelIR   = 4'h4,
        UpdDR   = 4'h5,
        CapDR   = 4'h6,
        SelDR   = 4'h7,
        Ex2IR   = 4'h8,
        Ex1IR   = 4'h9,
        ShIR    = 4'hA,
        PauseIR = 4'hB,
        RTI     = 4'hC,
        UpdIR   = 4'hD,
        CapIR   = 4'hE,
        TLR     = 4'hF
    } tapState_t;

    localparam logic [IR_WIDTH-1:0] BYPASS  = 3'b111;
    localparam logic [IR_WIDTH-1:0] INTEST  = 3'b011;
    localparam logic [IR_WIDTH-1:0] SAMPLE  = 3'b010;
    localparam logic [IR_WIDTH-1:0] PRELOAD = 3'b001;
    localparam logic [IR_WIDTH-1:0] EXTEST  = 3'b000;

    // IR column spans Select-IR-Scan through Update-IR.
    function automatic logic isIrColumn(input tapState_t s);
        return (s == SelIR) || (s == CapIR) || (s == ShIR) || (s == Ex1IR) ||
               (s == PauseIR) || (s == Ex2IR) || (s == UpdIR);
    endfunction

    function automatic logic isShiftState(input tapState_t s);
        return (s == ShDR) || (s == ShIR);
    endfunction

endpackage

// File: rtl/tap_ir_reg.sv
// Instruction register: serial shift stage plus the parallel Instruction latch
// presented to the boundary-scan decoder.
module tap_ir_reg #(
    parameter int                  IR_WIDTH   = tap_pkg::IR_WIDTH,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 3'b001,
    parameter logic [IR_WIDTH-1:0] IR_RESET   = 3'b111
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                captureEn,
    input  logic                shiftEn,
    input  logic                updateEn,
    input  logic                forceReset,
    input  logic                tdi,
    output logic [IR_WIDTH-1:0] instruction,
    output logic                irTdo
);
    import tap_pkg::*;

    logic [IR_WIDTH-1:0] shiftStage;

    // Pause and Exit states simply leave the stage untouched.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shiftStage <= IR_CAPTURE;
        end else if (captureEn) begin
            shiftStage <= IR_CAPTURE;
        end else if (shiftEn) begin
            shiftStage <= {tdi, shiftStage[IR_WIDTH-1:1]};
        end
    end

    // Only Update-IR changes the decoder's view, so DR scans never disturb it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            instruction <= IR_RESET;
        end else if (forceReset) begin
            instruction <= IR_RESET;
        end else if (updateEn) begin
            instruction <= shiftStage;
        end
    end

    assign irTdo = shiftStage[0];

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with registered strobes and an integrated
// instruction register feeding the boundary-scan decoder.
//
// state   | meaning
// TLR     | Test-Logic-Reset, Instruction forced to BYPASS
// RTI     | Run-Test/Idle
// SelDR   | Select-DR-Scan
// CapDR   | Capture-DR
// ShDR    | Shift-DR
// Ex1DR   | Exit1-DR
// PauseDR | Pause-DR
// Ex2DR   | Exit2-DR
// UpdDR   | Update-DR
// SelIR..UpdIR | IR-column mirror of the DR column
module tap_controller #(
    parameter int                  IR_WIDTH   = tap_pkg::IR_WIDTH,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 3'b001,
    parameter logic [IR_WIDTH-1:0] IR_RESET   = 3'b111
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic [IR_WIDTH-1:0] Instruction,
    output logic                IR_TDO,
    output logic [3:0]          TAPState,
    output logic                ResetTAP,
    output logic                ShiftDR,
    output logic                ClockDR,
    output logic                UpdateDR,
    output logic                ShiftIR,
    output logic                UpdateIR,
    output logic                Select,
    output logic                Enable
);
    import tap_pkg::*;

    tapState_t state;
    tapState_t nextState;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state <= TLR;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            TLR:     nextState = TMS ? TLR     : RTI;
            RTI:     nextState = TMS ? SelDR   : RTI;
            SelDR:   nextState = TMS ? SelIR   : CapDR;
            CapDR:   nextState = TMS ? Ex1DR   : ShDR;
            ShDR:    nextState = TMS ? Ex1DR   : ShDR;
            Ex1DR:   nextState = TMS ? UpdDR   : PauseDR;
            PauseDR: nextState = TMS ? Ex2DR   : PauseDR;
            Ex2DR:   nextState = TMS ? UpdDR   : ShDR;
            UpdDR:   nextState = TMS ? SelDR   : RTI;
            SelIR:   nextState = TMS ? TLR     : CapIR;
            CapIR:   nextState = TMS ? Ex1IR   : ShIR;
            ShIR:    nextState = TMS ? Ex1IR   : ShIR;
            Ex1IR:   nextState = TMS ? UpdIR   : PauseIR;
            PauseIR: nextState = TMS ? Ex2IR   : PauseIR;
            Ex2IR:   nextState = TMS ? UpdIR   : ShIR;
            UpdIR:   nextState = TMS ? SelDR   : RTI;
            default: nextState = TLR;
        endcase
    end

    // Strobes decode nextState so they flip on the same edge as TAPState.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ResetTAP <= 1'b1;
            ShiftDR  <= 1'b0;
            ClockDR  <= 1'b0;
            UpdateDR <= 1'b0;
            ShiftIR  <= 1'b0;
            UpdateIR <= 1'b0;
            Select   <= 1'b0;
            Enable   <= 1'b0;
        end else begin
            ResetTAP <= (nextState == TLR);
            ShiftDR  <= (nextState == ShDR);
            ClockDR  <= (nextState == CapDR) || (nextState == ShDR);
            UpdateDR <= (nextState == UpdDR);
            ShiftIR  <= (nextState == ShIR);
            UpdateIR <= (nextState == UpdIR);
            Select   <= isIrColumn(nextState);
            Enable   <= isShiftState(nextState);
        end
    end

    assign TAPState = state;

    // IR actions belong to the edge taken while in the named state.
    logic irCapture;
    logic irShift;
    logic irUpdate;
    logic irForce;

    assign irCapture = (state == CapIR);
    assign irShift   = (state == ShIR);
    assign irUpdate  = (state == UpdIR);
    assign irForce   = (state == TLR);

    tap_ir_reg #(
        .IR_WIDTH   (IR_WIDTH),
        .IR_CAPTURE (IR_CAPTURE),
        .IR_RESET   (IR_RESET)
    ) u_irReg (
        .clk         (TCK),
        .rstN        (TRST),
        .captureEn   (irCapture),
        .shiftEn     (irShift),
        .updateEn    (irUpdate),
        .forceReset  (irForce),
        .tdi         (TDI),
        .instruction (Instruction),
        .irTdo       (IR_TDO)
    );

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed TAP walks plus random TMS/TDI traffic,
// all compared against a table-driven reference model.
module tb_tap_controller;

    logic       TCK;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic [2:0] Instruction;
    logic       IR_TDO;
    logic [3:0] TAPState;
    logic       ResetTAP, ShiftDR, ClockDR, UpdateDR, ShiftIR, UpdateIR, Select, Enable;

    tap_controller dut (
        .TCK         (TCK),
        .TRST        (TRST),
        .TMS         (TMS),
        .TDI         (TDI),
        .Instruction (Instruction),
        .IR_TDO      (IR_TDO),
        .TAPState    (TAPState),
        .ResetTAP    (ResetTAP),
        .ShiftDR     (ShiftDR),
        .ClockDR     (ClockDR),
        .UpdateDR    (UpdateDR),
        .ShiftIR     (ShiftIR),
        .UpdateIR    (UpdateIR),
        .Select      (Select),
        .Enable      (Enable)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // Successor tables indexed by the hex state code.
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int         mState;
    logic [2:0] mInstr;
    logic [2:0] mIr;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] expFlags(input int s);
        logic [7:0] f;
        f[7] = (s == 15);
        f[6] = (s == 2);
        f[5] = (s == 6) || (s == 2);
        f[4] = (s == 5);
        f[3] = (s == 10);
        f[2] = (s == 13);
        f[1] = (s == 4) || (s == 14) || (s == 10) || (s == 9) ||
               (s == 11) || (s == 8) || (s == 13);
        f[0] = (s == 2) || (s == 10);
        return f;
    endfunction

    task automatic modelReset();
        mState = 15;
        mInstr = 3'b111;
        mIr    = 3'b001;
    endtask

    task automatic modelEdge(input logic tms, input logic tdi);
        if (mState == 14) mIr = 3'b001;
        else if (mState == 10) mIr = (mIr >> 1) | ({2'b00, tdi} << 2);
        if (mState == 13) mInstr = mIr;
        else if (mState == 15) mInstr = 3'b111;
        mState = tms ? nxt1[mState] : nxt0[mState];
    endtask

    task automatic compareAll(input string tag);
        check({tag, ".state"}, 32'(TAPState), 32'(mState));
        check({tag, ".instr"}, 32'(Instruction), 32'(mInstr));
        check({tag, ".irTdo"}, 32'(IR_TDO), 32'(mIr[0]));
        check({tag, ".flags"},
              32'({ResetTAP, ShiftDR, ClockDR, UpdateDR, ShiftIR, UpdateIR, Select, Enable}),
              32'(expFlags(mState)));
    endtask

    task automatic step(input logic tms, input logic tdi, input string tag);
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        modelEdge(tms, tdi);
        #1;
        compareAll(tag);
    endtask

    task automatic tmsSeq(input logic [15:0] bits, input int n, input string tag);
        for (int i = 0; i < n; i++) step(bits[i], 1'b0, tag);
    endtask

    // Reset asserted between edges; outputs must settle with no TCK edge.
    task automatic asyncReset(input string tag);
        #2;
        TRST = 1'b0;
        #1;
        modelReset();
        compareAll(tag);
        #1;
        TRST = 1'b1;
    endtask

    initial begin
        TRST = 1'b0;
        TMS  = 1'b1;
        TDI  = 1'b0;
        modelReset();
        #7;
        compareAll("por");
        #1;
        TRST = 1'b1;

        // Into Shift-DR, then reset mid-scan.
        tmsSeq(16'b0010, 4, "toShDR");
        check("inShDR", 32'(TAPState), 32'h2);
        asyncReset("trstShDR");
        check("trstState", 32'(TAPState), 32'hF);

        // Five TMS=1 from RTI.
        step(1'b0, 1'b0, "toRti");
        tmsSeq(16'b11111, 5, "fiveOnes");
        check("fiveOnesInstr", 32'(Instruction), 32'h7);

        // Load INTEST: RTI -> SelDR -> SelIR -> CapIR -> ShIR.
        step(1'b0, 1'b0, "rti");
        tmsSeq(16'b0011, 4, "toShIR");
        check("capTdo", 32'(IR_TDO), 32'h1);
        step(1'b0, 1'b1, "shIr0");
        step(1'b0, 1'b1, "shIr1");
        step(1'b1, 1'b0, "shIr2");
        step(1'b1, 1'b0, "updIr");
        check("updIrInstrOld", 32'(Instruction), 32'h7);
        step(1'b0, 1'b0, "leaveUpdIr");
        check("intest", 32'(Instruction), 32'h3);

        // DR scan with INTEST loaded.
        tmsSeq(16'b0001, 4, "drScan");
        step(1'b0, 1'b1, "drShift");
        tmsSeq(16'b011, 3, "drExit");
        check("drInstr", 32'(Instruction), 32'h3);

        // IR pause and resume.
        tmsSeq(16'b0011, 4, "pToShIR");
        step(1'b0, 1'b0, "pShift");
        tmsSeq(16'b1000001, 7, "pPause");
        step(1'b0, 1'b1, "pResume");
        tmsSeq(16'b011, 3, "pExit");

        // Abort IR scan after shifting zeros.
        tmsSeq(16'b0011, 4, "aToShIR");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "aShift");
        tmsSeq(16'b11111, 5, "abort");
        check("abortState", 32'(TAPState), 32'hF);
        step(1'b1, 1'b0, "tlrHold");
        check("abortInstr", 32'(Instruction), 32'h7);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99) < 35) ? 1'b1 : 1'b0, 1'($urandom), "rnd");
            if ($urandom_range(199) == 0) asyncReset("rndTrst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
